// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit 7-segment display.
//   Keeps a double-buffered frame (staging + active) and lights one digit at a
//   time. Each digit slot is an all-off BLANK gap followed by a SHOW window.
//   Staged frames are committed to the active frame only at frame boundaries,
//   so a frame in progress is never mixed with a newer one.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   seg_in      new frame, digit k in bits [7k+6:7k]
//   load_req    strobe: capture seg_in into staging
//   load_ack    pulse in the cycle staging is committed to the active frame
//   digit_en    per-digit enable (registered before use)
//   blank_all   forces all anodes off (registered before use)
//   seg_out     segment pattern of the current digit
//   anode_n     active-low digit enables
//   digit_sel   index of the current digit
//   frame_tick  pulse in the last SHOW cycle of the last digit
//
// State table
//   state    | meaning
//   ST_BLANK | all anodes off for BLANK_CYCLES before the digit is lit
//   ST_SHOW  | current digit lit for PRESCALE cycles
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7*NUM_DIGITS-1:0]       seg_in,
    input  logic                          load_req,
    output logic                          load_ack,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          blank_all,
    output logic [6:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic                          frame_tick
);

    localparam int CNT_SPAN = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW       = $clog2((CNT_SPAN > 2) ? CNT_SPAN : 2);
    localparam int SW       = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [SW-1:0] SEL_LAST   = SW'(NUM_DIGITS - 1);

    typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

    // First state of every digit slot; with no blanking gap the FSM lives in SHOW.
    localparam state_t ST_ENTRY = state_t'((BLANK_CYCLES == 0) ? 1'b1 : 1'b0);

    state_t                       state, state_nxt;
    logic [CW-1:0]                cnt, cnt_nxt;
    logic [SW-1:0]                sel_nxt;
    logic [NUM_DIGITS-1:0]        en_q;
    logic                         blank_q;
    logic [NUM_DIGITS-1:0][6:0]   staging;
    logic [NUM_DIGITS-1:0][6:0]   active;
    logic                         pending;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ENTRY;
            cnt       <= '0;
            digit_sel <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            digit_sel <= sel_nxt;
        end
    end

    // Next-state logic; digit_sel advances as a SHOW window closes, so the
    // following BLANK gap already belongs to the next digit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        sel_nxt   = digit_sel;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt == SHOW_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_ENTRY;
                    sel_nxt   = (digit_sel == SEL_LAST) ? '0 : digit_sel + SW'(1);
                end
            end
        endcase
    end

    // Output decode, from registered state only
    always_comb begin
        seg_out    = '0;
        anode_n    = '1;
        frame_tick = (state == ST_SHOW) && (cnt == SHOW_LAST) && (digit_sel == SEL_LAST);
        load_ack   = frame_tick & pending;
        if (state == ST_SHOW) begin
            seg_out            = active[digit_sel];
            anode_n[digit_sel] = ~(en_q[digit_sel] & ~blank_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= '0;
            blank_q <= 1'b0;
        end else begin
            en_q    <= digit_en;
            blank_q <= blank_all;
        end
    end

    // A load arriving in the commit cycle overwrites staging after the old
    // contents have been committed, and keeps pending set for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (load_ack) begin
                active <= staging;
            end
            if (load_req) begin
                staging <= seg_in;
                pending <= 1'b1;
            end else if (load_ack) begin
                pending <= 1'b0;
            end
        end
    end

endmodule
